// File: rtl/cic_interpolator.sv
// CIC interpolator (N comb, zero-stuff by R, N integrators); out_valid from T+N+2, one sample per clock.
// Backpressure: in_ready only while idle or at the due phase; CIC_INTERP_UNDERRUN_EN adds an underrun pulse.
module cic_interpolator #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1,
  parameter int RATE   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef CIC_INTERP_UNDERRUN_EN
  ,
  output logic             underrun
`endif
);

  localparam int LR = $clog2(RATE);
  localparam int IW = WIDTH + STAGES * LR;
  localparam int S  = (STAGES - 1) * LR;
  localparam logic [LR-1:0] PH_LAST = LR'(RATE - 1);

  logic          running;
  logic [LR-1:0] phase;
  logic          due;
  logic          urun_evt;
  logic          take;
  logic          fresh;
  logic [IW-1:0] x_in;
  logic [IW-1:0] cval [STAGES+1];
  logic [IW-1:0] cprev [STAGES];
  logic [IW-1:0] comb_reg;
  logic [IW-1:0] integ_in;
  logic [IW-1:0] acc [STAGES];
  logic [STAGES:0] vld_sr;

  assign due      = running && (phase == PH_LAST);
  assign in_ready = !running || due;
  assign urun_evt = due && !in_valid;
  // A missed due slot is treated as an accepted zero so the output cadence never stalls.
  assign take     = (in_ready && in_valid) || urun_evt;
  assign x_in     = in_valid ? {{(IW-WIDTH){in[WIDTH-1]}}, in} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      phase   <= '0;
      fresh   <= 1'b0;
    end else begin
      fresh <= take;
      if (running) begin
        phase <= phase + 1'b1;
      end else if (take) begin
        running <= 1'b1;
      end
    end
  end

  assign cval[0] = x_in;

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_comb
      assign cval[g+1] = cval[g] - cprev[g];

      always_ff @(posedge clk) begin
        if (rst) begin
          cprev[g] <= '0;
        end else if (take) begin
          cprev[g] <= cval[g];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      comb_reg <= '0;
    end else if (take) begin
      comb_reg <= cval[STAGES];
    end
  end

  // Zero stuffing: the comb result enters the integrators only on the cycle right after an accept.
  assign integ_in = fresh ? comb_reg : '0;

  generate
    for (g = 0; g < STAGES; g++) begin : g_integ
      if (g == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) begin
            acc[g] <= '0;
          end else if (running) begin
            acc[g] <= acc[g] + integ_in;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) begin
            acc[g] <= '0;
          end else if (running) begin
            acc[g] <= acc[g] + acc[g-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '0;
      vld_sr <= '0;
    end else begin
      out    <= acc[STAGES-1][WIDTH-1+S:S];
      vld_sr <= {vld_sr[STAGES-1:0], running};
    end
  end

  assign out_valid = vld_sr[STAGES];

`ifdef CIC_INTERP_UNDERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else begin
      underrun <= urun_evt;
    end
  end
`endif

endmodule
